// File: rtl/ysyx_23060240_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between IFU (read-only) and LSU, one transaction in flight.
// One cycle of arbitration latency; masters and memory are stalled purely through valid/ready, with a response watchdog.
module ysyx_23060240_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              if_req_valid,
  output logic              if_req_ready,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_resp_valid,
  input  logic              if_resp_ready,
  output logic [DATA_W-1:0] if_rdata,

  input  logic              ls_req_valid,
  output logic              ls_req_ready,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              ls_wen,
  input  logic [DATA_W-1:0] ls_wdata,
  input  logic [7:0]        ls_wmask,
  output logic              ls_resp_valid,
  input  logic              ls_resp_ready,
  output logic [DATA_W-1:0] ls_rdata,

  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [7:0]        mem_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              resp_err,
  output logic              busy
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [2:0] {
    IDLE,
    REQ_IF,
    REQ_LS,
    RSP_IF,
    RSP_LS
  } state_t;

  state_t            state, state_nxt;
  logic              last_grant, last_grant_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              timed_out;

  // With TIMEOUT = 0 the comparison is never true, so the watchdog is inert.
  assign timed_out = (TIMEOUT > 0) && (cnt == CNT_W'(TIMEOUT));
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      cnt        <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    cnt_nxt        = cnt;

    if_req_ready   = 1'b0;
    if_resp_valid  = 1'b0;
    if_rdata       = '0;
    ls_req_ready   = 1'b0;
    ls_resp_valid  = 1'b0;
    ls_rdata       = '0;
    mem_req_valid  = 1'b0;
    mem_addr       = '0;
    mem_wen        = 1'b0;
    mem_wdata      = '0;
    mem_wmask      = '0;
    mem_resp_ready = 1'b0;
    resp_err       = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the master that was not granted last time wins.
        if (if_req_valid && (!ls_req_valid || last_grant)) begin
          state_nxt      = REQ_IF;
          last_grant_nxt = 1'b0;
        end else if (ls_req_valid) begin
          state_nxt      = REQ_LS;
          last_grant_nxt = 1'b1;
        end
      end

      REQ_IF: begin
        mem_req_valid = if_req_valid;
        mem_addr      = if_addr;
        if_req_ready  = mem_req_ready;
        if (if_req_valid && mem_req_ready) begin
          state_nxt = RSP_IF;
          cnt_nxt   = '0;
        end else if (!if_req_valid) begin
          state_nxt = IDLE;
        end
      end

      REQ_LS: begin
        mem_req_valid = ls_req_valid;
        mem_addr      = ls_addr;
        mem_wen       = ls_wen;
        mem_wdata     = ls_wdata;
        mem_wmask     = ls_wmask;
        ls_req_ready  = mem_req_ready;
        if (ls_req_valid && mem_req_ready) begin
          state_nxt = RSP_LS;
          cnt_nxt   = '0;
        end else if (!ls_req_valid) begin
          state_nxt = IDLE;
        end
      end

      RSP_IF: begin
        if (timed_out) begin
          // Forced error response; memory is no longer listened to.
          if_resp_valid = 1'b1;
          resp_err      = 1'b1;
          if (if_resp_ready) state_nxt = IDLE;
        end else begin
          if_resp_valid  = mem_resp_valid;
          if_rdata       = mem_rdata;
          mem_resp_ready = if_resp_ready;
          if (mem_resp_valid && if_resp_ready) begin
            state_nxt = IDLE;
          end else if (!mem_resp_valid && (TIMEOUT > 0)) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      RSP_LS: begin
        if (timed_out) begin
          ls_resp_valid = 1'b1;
          resp_err      = 1'b1;
          if (ls_resp_ready) state_nxt = IDLE;
        end else begin
          ls_resp_valid  = mem_resp_valid;
          ls_rdata       = mem_rdata;
          mem_resp_ready = ls_resp_ready;
          if (mem_resp_valid && ls_resp_ready) begin
            state_nxt = IDLE;
          end else if (!mem_resp_valid && (TIMEOUT > 0)) begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule
